// File: rtl/fpu_addnorm_pkg.sv
// rtl/fpu_addnorm_pkg.sv - shared widths and request bundle for the add/sub post-normalization scheduler
package fpu_addnorm_pkg;

    localparam int MAN_DEF   = 22;
    localparam int EXP_DEF   = 7;
    localparam int TAG_W_DEF = 4;

    localparam int MANT_W  = 2*MAN_DEF + 4;
    localparam int NMANT_W = MAN_DEF + 2;
    localparam int EXPW    = EXP_DEF + 2;

    typedef struct packed {
        logic [MANT_W-1:0]    mantissa;
        logic [EXPW-1:0]      exponent;
        logic                 carry;
        logic                 eff_sub;
        logic                 eff_add;
        logic [2:0]           grs;
        logic [TAG_W_DEF-1:0] tag;
    } addnorm_req_t;

endpackage

// File: rtl/fpu_rr_arbiter2.sv
// rtl/fpu_rr_arbiter2.sv - two-way round-robin grant; pointer moves past the winner on accept
module fpu_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_l,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic rr_ptr;

    always_comb begin
        grant    = 2'b00;
        grant[0] = valid[0] & (~valid[1] | ~rr_ptr);
        grant[1] = valid[1] & (~valid[0] |  rr_ptr);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= ~grant[1];
        end
    end

endmodule

// File: rtl/fmadd_addnorm_scheduler.sv
// rtl/fmadd_addnorm_scheduler.sv - time-shares one add/sub post-normalization datapath between two requesters
module fmadd_addnorm_scheduler
    import fpu_addnorm_pkg::*;
#(
    parameter int MAN   = MAN_DEF,
    parameter int EXP   = EXP_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 flush,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [2*MAN+3:0]     req0_mantissa,
    input  logic [EXP+1:0]       req0_exponent,
    input  logic                 req0_carry,
    input  logic                 req0_eff_sub,
    input  logic                 req0_eff_add,
    input  logic [2:0]           req0_grs,
    input  logic [TAG_W-1:0]     req0_tag,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [2*MAN+3:0]     req1_mantissa,
    input  logic [EXP+1:0]       req1_exponent,
    input  logic                 req1_carry,
    input  logic                 req1_eff_sub,
    input  logic                 req1_eff_add,
    input  logic [2:0]           req1_grs,
    input  logic [TAG_W-1:0]     req1_tag,

    output logic [2*MAN+3:0]     pn_mantissa,
    output logic [EXP+1:0]       pn_exponent,
    output logic                 pn_carry,
    output logic                 pn_eff_sub,
    output logic                 pn_eff_add,
    output logic                 pn_guard,
    output logic                 pn_round,
    output logic                 pn_sticky,

    input  logic [MAN+1:0]       pn_res_mantissa,
    input  logic [EXP+1:0]       pn_res_exponent,
    input  logic [2:0]           pn_res_grs,

    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [MAN+1:0]       res_mantissa,
    output logic [EXP+1:0]       res_exponent,
    output logic [2:0]           res_grs,
    output logic                 res_src,
    output logic [TAG_W-1:0]     res_tag,
    output logic                 err_illegal
);

    logic [1:0]   req_valid;
    logic [1:0]   grant;
    logic         s1_valid, s1_src;
    logic         s2_valid, s2_src;
    logic         s2_free, s1_adv, s1_load_ok, accept, win_illegal;
    addnorm_req_t req0, req1, win_req, s1_q;

    logic [MAN+1:0]   s2_mantissa;
    logic [EXP+1:0]   s2_exponent;
    logic [2:0]       s2_grs;
    logic [TAG_W-1:0] s2_tag;

    assign s2_free    = ~s2_valid | res_ready;
    assign s1_adv     = s1_valid & s2_free;
    assign s1_load_ok = ~s1_valid | s1_adv;
    assign req_valid  = {req1_valid, req0_valid};
    assign accept     = (|grant) & s1_load_ok & ~flush;
    assign req0_ready = grant[0] & s1_load_ok & ~flush;
    assign req1_ready = grant[1] & s1_load_ok & ~flush;

    fpu_rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_l  (rst_l),
        .valid  (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        req0 = '{mantissa: req0_mantissa, exponent: req0_exponent, carry: req0_carry,
                 eff_sub: req0_eff_sub, eff_add: req0_eff_add, grs: req0_grs, tag: req0_tag};
        req1 = '{mantissa: req1_mantissa, exponent: req1_exponent, carry: req1_carry,
                 eff_sub: req1_eff_sub, eff_add: req1_eff_add, grs: req1_grs, tag: req1_tag};
        win_req     = grant[1] ? req1 : req0;
        win_illegal = win_req.eff_sub & win_req.eff_add;
        // a request claiming both operations is treated as a subtraction
        win_req.eff_add = win_req.eff_add & ~win_req.eff_sub;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s1_valid    <= 1'b0;
            s1_src      <= 1'b0;
            s1_q        <= '0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= accept & win_illegal;
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (accept) begin
                s1_valid <= 1'b1;
                s1_src   <= grant[1];
                s1_q     <= win_req;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s2_valid    <= 1'b0;
            s2_src      <= 1'b0;
            s2_tag      <= '0;
            s2_mantissa <= '0;
            s2_exponent <= '0;
            s2_grs      <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s1_adv) begin
            s2_valid    <= 1'b1;
            s2_src      <= s1_src;
            s2_tag      <= s1_q.tag;
            s2_mantissa <= pn_res_mantissa;
            s2_exponent <= pn_res_exponent;
            s2_grs      <= pn_res_grs;
        end else if (res_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign pn_mantissa = s1_q.mantissa;
    assign pn_exponent = s1_q.exponent;
    assign pn_carry    = s1_q.carry;
    assign pn_eff_sub  = s1_q.eff_sub;
    assign pn_eff_add  = s1_q.eff_add;
    assign pn_guard    = s1_q.grs[2];
    assign pn_round    = s1_q.grs[1];
    assign pn_sticky   = s1_q.grs[0];

    assign res_valid    = s2_valid;
    assign res_src      = s2_src;
    assign res_tag      = s2_tag;
    assign res_mantissa = s2_mantissa;
    assign res_exponent = s2_exponent;
    assign res_grs      = s2_grs;

endmodule
